// File: rtl/apb_completer_regs.sv
// rtl/apb_completer_regs.sv - APB completer with a byte-strobed register file and fixed wait states
module apb_completer_regs #(
    parameter int                ADDR_W      = 12,
    parameter int                DATA_W      = 32,
    parameter int                NUM_REGS    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_W-1:0]     PADDR,
    input  logic [DATA_W-1:0]     PWDATA,
    input  logic [DATA_W/8-1:0]   PSTRB,
    output logic [DATA_W-1:0]     PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [DATA_W-1:0]     reg0_out
);
    localparam int                STRB_W     = DATA_W / 8;
    localparam int                IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);
    localparam logic [3:0]        WAIT_INIT  = 4'(WAIT_CYCLES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   strb_q;
    logic [3:0]          cnt;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    logic [ADDR_W-1:0]   dec_addr;
    logic                dec_write;
    logic [ADDR_W:0]     offset_ext;
    logic [ADDR_W-1:0]   offset;
    logic [IDX_W-1:0]    dec_idx;
    logic                dec_valid;
    logic [DATA_W-1:0]   resp_data;

    // With zero wait states the response is registered on the setup edge,
    // before the address is latched, so decode looks at the live bus in IDLE.
    always_comb begin
        dec_addr   = (state == IDLE) ? PADDR  : addr_q;
        dec_write  = (state == IDLE) ? PWRITE : write_q;
        offset_ext = {1'b0, dec_addr} - {1'b0, BASE_ADDR};
        offset     = offset_ext[ADDR_W-1:0];
        dec_idx    = offset[IDX_W+1:2];
        dec_valid  = !offset_ext[ADDR_W] && (offset[1:0] == 2'b00) && ((offset >> 2) < NUM_REGS_A);
        resp_data  = '0;
        if (dec_valid && !dec_write) begin
            resp_data = regs[dec_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            cnt     <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (PSEL && !PENABLE) begin
                        addr_q  <= PADDR;
                        write_q <= PWRITE;
                        wdata_q <= PWDATA;
                        strb_q  <= PSTRB;
                        cnt     <= WAIT_INIT;
                        state   <= ACCESS;
                        if (WAIT_CYCLES == 0) begin
                            PREADY  <= 1'b1;
                            PSLVERR <= !dec_valid;
                            PRDATA  <= resp_data;
                        end
                    end
                end
                ACCESS: begin
                    if (!(PSEL && PENABLE)) begin
                        state   <= IDLE;
                        PREADY  <= 1'b0;
                        PSLVERR <= 1'b0;
                        PRDATA  <= '0;
                    end else if (PREADY) begin
                        if (write_q && dec_valid) begin
                            for (int i = 0; i < STRB_W; i++) begin
                                if (strb_q[i]) begin
                                    regs[dec_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                                end
                            end
                        end
                        state   <= IDLE;
                        PREADY  <= 1'b0;
                        PSLVERR <= 1'b0;
                        PRDATA  <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            PREADY  <= 1'b1;
                            PSLVERR <= !dec_valid;
                            PRDATA  <= resp_data;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign reg0_out = regs[0];

endmodule

// File: tb/tb_apb_completer_regs.sv
// tb/tb_apb_completer_regs.sv - scoreboard bench for apb_completer_regs at one and zero wait states
module tb_apb_completer_regs;
    logic        clk = 1'b0;
    logic        rst;
    logic        psel1, psel0, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata1, prdata0, reg0_1, reg0_0;
    logic        pready1, pready0, pslverr1, pslverr0;

    always #5 clk = ~clk;

    apb_completer_regs #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata1),
        .PREADY(pready1), .PSLVERR(pslverr1), .reg0_out(reg0_1)
    );

    apb_completer_regs #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata0),
        .PREADY(pready0), .PSLVERR(pslverr0), .reg0_out(reg0_0)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [16];
    int          checks = 0;
    int          failures = 0;

    function automatic exp_t mk_exp(input logic [31:0] rdata, input logic err, input int cyc);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.cyc   = cyc;
        return e;
    endfunction

    task automatic apb_idle();
        psel1   = 1'b0;
        psel0   = 1'b0;
        penable = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the completion edge
    // with the bus still driven so another setup phase can follow directly.
    task automatic apb_xfer(input bit use0, input bit wr, input logic [11:0] a,
                            input logic [31:0] d, input logic [3:0] s,
                            output logic [31:0] rd, output logic err, output int cyc);
        psel1   = !use0;
        psel0   = use0;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        pstrb   = s;
        @(posedge clk); #1;
        penable = 1'b1;
        pwdata  = ~d;
        paddr   = a ^ 12'h004;
        cyc = -1;
        rd  = 'x;
        err = 'x;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (use0 ? pready0 : pready1) begin
                cyc = k;
                rd  = use0 ? prdata0 : prdata1;
                err = use0 ? pslverr0 : pslverr1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apb_idle();
        pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
        #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({pready1, pslverr1, prdata1, reg0_1} !== 66'd0) begin
            failures++;
            $display("FAIL reset_w1: pready=%b pslverr=%b prdata=%h reg0=%h, expected all zero", pready1, pslverr1, prdata1, reg0_1);
        end
        checks++;
        if ({pready0, pslverr0, prdata0, reg0_0} !== 66'd0) begin
            failures++;
            $display("FAIL reset_w0: pready=%b pslverr=%b prdata=%h reg0=%h, expected all zero", pready0, pslverr0, prdata0, reg0_0);
        end
        for (int i = 0; i < 16; i++) model[i] = '0;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic err; int cyc; exp_t e;
        exp_q.push_back(mk_exp(32'h0, 1'b0, 2));
        apb_xfer(0, 1, 12'h008, 32'hDEADBEEF, 4'hF, rd, err, cyc);
        model[2] = 32'hDEADBEEF;
        e = exp_q.pop_front();
        checks++;
        if (rd !== e.rdata || err !== e.err || cyc !== e.cyc) begin
            failures++;
            $display("FAIL basic_write: rdata=%h err=%b cyc=%0d, expected rdata=%h err=%b cyc=%0d", rd, err, cyc, e.rdata, e.err, e.cyc);
        end
        exp_q.push_back(mk_exp(32'hDEADBEEF, 1'b0, 2));
        apb_xfer(0, 0, 12'h008, 32'h0, 4'h0, rd, err, cyc);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e.rdata || err !== e.err || cyc !== e.cyc) begin
            failures++;
            $display("FAIL basic_read: rdata=%h err=%b cyc=%0d, expected rdata=%h err=%b cyc=%0d", rd, err, cyc, e.rdata, e.err, e.cyc);
        end
        apb_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_strobes();
        logic [31:0] rd; logic err; int cyc; exp_t e;
        exp_q.push_back(mk_exp(32'h0, 1'b0, 2));
        apb_xfer(0, 1, 12'h008, 32'h11223344, 4'b0101, rd, err, cyc);
        model[2] = 32'hDE22BE44;
        e = exp_q.pop_front();
        checks++;
        if (rd !== e.rdata || err !== e.err || cyc !== e.cyc) begin
            failures++;
            $display("FAIL strobe_write: rdata=%h err=%b cyc=%0d, expected rdata=%h err=%b cyc=%0d", rd, err, cyc, e.rdata, e.err, e.cyc);
        end
        exp_q.push_back(mk_exp(32'hDE22BE44, 1'b0, 2));
        apb_xfer(0, 0, 12'h008, 32'h0, 4'h0, rd, err, cyc);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e.rdata || err !== e.err || cyc !== e.cyc) begin
            failures++;
            $display("FAIL strobe_read: rdata=%h err=%b cyc=%0d, expected rdata=%h err=%b cyc=%0d", rd, err, cyc, e.rdata, e.err, e.cyc);
        end
        apb_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_wait0();
        logic [31:0] rd; logic err; int cyc; exp_t e;
        exp_q.push_back(mk_exp(32'h0, 1'b0, 1));
        apb_xfer(1, 1, 12'h000, 32'h5, 4'hF, rd, err, cyc);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e.rdata || err !== e.err || cyc !== e.cyc) begin
            failures++;
            $display("FAIL wait0_write: rdata=%h err=%b cyc=%0d, expected rdata=%h err=%b cyc=%0d", rd, err, cyc, e.rdata, e.err, e.cyc);
        end
        checks++;
        if (reg0_0 !== 32'h5) begin
            failures++;
            $display("FAIL wait0_reg0_out: reg0_out=%h, expected %h", reg0_0, 32'h5);
        end
        exp_q.push_back(mk_exp(32'h5, 1'b0, 1));
        apb_xfer(1, 0, 12'h000, 32'h0, 4'h0, rd, err, cyc);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e.rdata || err !== e.err || cyc !== e.cyc) begin
            failures++;
            $display("FAIL wait0_read: rdata=%h err=%b cyc=%0d, expected rdata=%h err=%b cyc=%0d", rd, err, cyc, e.rdata, e.err, e.cyc);
        end
        apb_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int cyc; exp_t e;
        exp_q.push_back(mk_exp(32'h0, 1'b1, 2));
        apb_xfer(0, 0, 12'h006, 32'h0, 4'h0, rd, err, cyc);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e.rdata || err !== e.err || cyc !== e.cyc) begin
            failures++;
            $display("FAIL err_misaligned: rdata=%h err=%b cyc=%0d, expected rdata=%h err=%b cyc=%0d", rd, err, cyc, e.rdata, e.err, e.cyc);
        end
        exp_q.push_back(mk_exp(32'h0, 1'b1, 2));
        apb_xfer(0, 1, 12'h040, 32'hFFFFFFFF, 4'hF, rd, err, cyc);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e.rdata || err !== e.err || cyc !== e.cyc) begin
            failures++;
            $display("FAIL err_range_write: rdata=%h err=%b cyc=%0d, expected rdata=%h err=%b cyc=%0d", rd, err, cyc, e.rdata, e.err, e.cyc);
        end
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(mk_exp(model[i], 1'b0, 2));
            apb_xfer(0, 0, 12'(4 * i), 32'h0, 4'h0, rd, err, cyc);
            e = exp_q.pop_front();
            checks++;
            if (rd !== e.rdata || err !== e.err || cyc !== e.cyc) begin
                failures++;
                $display("FAIL err_readback[%0d]: rdata=%h err=%b cyc=%0d, expected rdata=%h err=%b cyc=%0d", i, rd, err, cyc, e.rdata, e.err, e.cyc);
            end
        end
        apb_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic err; int cyc; exp_t e;
        bit saw_ready = 0;
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'h00C; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
        @(posedge clk); #1;
        @(negedge clk); saw_ready |= pready1;
        @(posedge clk); #1;
        psel1 = 1'b0;
        repeat (3) begin
            @(negedge clk); saw_ready |= pready1;
        end
        @(posedge clk); #1;
        psel1 = 1'b1; penable = 1'b1;
        repeat (3) begin
            @(negedge clk); saw_ready |= pready1;
        end
        @(posedge clk); #1;
        apb_idle();
        checks++;
        if (saw_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_pready: pready seen=%b, expected 0", saw_ready);
        end
        @(posedge clk); #1;
        exp_q.push_back(mk_exp(model[3], 1'b0, 2));
        apb_xfer(0, 0, 12'h00C, 32'h0, 4'h0, rd, err, cyc);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e.rdata || err !== e.err || cyc !== e.cyc) begin
            failures++;
            $display("FAIL abort_readback: rdata=%h err=%b cyc=%0d, expected rdata=%h err=%b cyc=%0d", rd, err, cyc, e.rdata, e.err, e.cyc);
        end
        apb_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err; int cyc; exp_t e;
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            d = $urandom | 32'h1;
            exp_q.push_back(mk_exp(32'h0, 1'b0, 2));
            apb_xfer(0, 1, 12'(4 * i), d, 4'hF, rd, err, cyc);
            model[i] = d;
            e = exp_q.pop_front();
            checks++;
            if (rd !== e.rdata || err !== e.err || cyc !== e.cyc) begin
                failures++;
                $display("FAIL b2b_write[%0d]: rdata=%h err=%b cyc=%0d, expected rdata=%h err=%b cyc=%0d", i, rd, err, cyc, e.rdata, e.err, e.cyc);
            end
        end
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(mk_exp(model[i], 1'b0, 2));
            apb_xfer(0, 0, 12'(4 * i), 32'h0, 4'h0, rd, err, cyc);
            e = exp_q.pop_front();
            checks++;
            if (rd !== e.rdata || err !== e.err || cyc !== e.cyc) begin
                failures++;
                $display("FAIL b2b_read[%0d]: rdata=%h err=%b cyc=%0d, expected rdata=%h err=%b cyc=%0d", i, rd, err, cyc, e.rdata, e.err, e.cyc);
            end
        end
        apb_idle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err; int cyc; exp_t e;
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'h014; pwdata = 32'hA5A5A5A5; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({pready1, pslverr1, prdata1, reg0_1} !== 66'd0) begin
            failures++;
            $display("FAIL reset_mid_w1: pready=%b pslverr=%b prdata=%h reg0=%h, expected all zero", pready1, pslverr1, prdata1, reg0_1);
        end
        checks++;
        if (reg0_0 !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_w0_reg0: reg0=%h, expected 0", reg0_0);
        end
        apb_idle();
        for (int i = 0; i < 16; i++) model[i] = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(mk_exp(model[i], 1'b0, 2));
            apb_xfer(0, 0, 12'(4 * i), 32'h0, 4'h0, rd, err, cyc);
            e = exp_q.pop_front();
            checks++;
            if (rd !== e.rdata || err !== e.err || cyc !== e.cyc) begin
                failures++;
                $display("FAIL reset_mid_readback[%0d]: rdata=%h err=%b cyc=%0d, expected rdata=%h err=%b cyc=%0d", i, rd, err, cyc, e.rdata, e.err, e.cyc);
            end
        end
        apb_idle();
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_strobes();
        test_wait0();
        test_errors();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/apb_completer_regs.md
Name: apb_completer_regs

Overview:
- APB responder (completer) terminating one decoded port of the APB interconnect.
- Holds NUM_REGS 32-bit read/write registers with byte strobes and programmable wait states.
- Flags misaligned or out-of-range accesses with PSLVERR.
- Register 0 is exported as a control word for the attached peripheral.

Parameters:
- ADDR_W, 12, address width; matches interconnect addr_out*.
- DATA_W, 32, data width; fixed at 32, PSTRB width = DATA_W/8.
- NUM_REGS, 16, number of word registers (1..256).
- BASE_ADDR, 12'h000, byte address of register 0; word aligned.
- WAIT_CYCLES, 1, wait cycles inserted in the access phase (0..15).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset.
- PSEL  input  1  completer select from interconnect.
- PENABLE  input  1  access-phase indicator.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  ADDR_W  byte address.
- PWDATA  input  DATA_W  write data.
- PSTRB  input  DATA_W/8  write byte strobes; PSTRB[i] enables byte i.
- PRDATA  output  DATA_W  read data; valid only while PREADY=1 on a read.
- PREADY  output  1  transfer completion, registered.
- PSLVERR  output  1  transfer error; valid only while PREADY=1.
- reg0_out  output  DATA_W  current contents of register 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; PREADY=0, PSLVERR=0, PRDATA=0.
  - Wait counter = 0; all registers = 0, so reg0_out = 0.
- States: IDLE, ACCESS.
- IDLE:
  - On an edge with PSEL=1 and PENABLE=0 (setup phase):
    - Latch PADDR, PWRITE, PWDATA, PSTRB.
    - Load cnt = WAIT_CYCLES.
    - Set PREADY = (WAIT_CYCLES==0).
    - Go to ACCESS.
  - PSEL=1 with PENABLE=1 while in IDLE (no setup phase) is ignored: no PREADY, no write.
- ACCESS, PREADY=0:
  - Each edge with PSEL=1 and PENABLE=1: cnt <= cnt-1; PREADY <= (cnt==1).
  - The access phase therefore lasts exactly WAIT_CYCLES+1 cycles.
- Decode, from latched address:
  - idx = (PADDR - BASE_ADDR) >> 2.
  - Valid iff PADDR >= BASE_ADDR, idx < NUM_REGS and PADDR[1:0]==0.
- Response values, registered on the same edge that sets PREADY=1:
  - PSLVERR = !valid.
  - PRDATA = reg[idx] for a valid read; 0 for writes and for errors.
- Completion edge (PREADY=1, PSEL=1, PENABLE=1):
  - Valid write: byte i of reg[idx] <= PWDATA byte i when PSTRB[i]=1; other bytes unchanged.
  - Invalid write: no register changes.
  - Read: no side effects.
  - PREADY, PSLVERR and PRDATA return to 0; state goes to IDLE.
- Back-to-back transfers: a new setup phase in the cycle right after completion is accepted normally; there is no dead cycle.
- Abort: PSEL or PENABLE dropping while in ACCESS:
  - Go to IDLE; PREADY=PSLVERR=0, PRDATA=0.
  - No register write.
- Data hold: PWDATA/PADDR changes during ACCESS are ignored; latched values are used.
- reg0_out reflects register 0 from the edge after the write completes.
- Reset mid-transfer: immediate return to reset values; the pending write is discarded.

Test Plan:
- WAIT_CYCLES=1:
  - Stimulus: write 32'hDEADBEEF to 12'h008 with PSTRB=4'hF, then read 12'h008.
  - Required: PREADY rises in the 2nd access cycle of each transfer; PRDATA=32'hDEADBEEF and PSLVERR=0 on the read.
- Byte strobes:
  - Stimulus: with reg2=32'hDEADBEEF, write 32'h11223344 to 12'h008 with PSTRB=4'b0101.
  - Required: a read returns 32'hDE22BE44.
- WAIT_CYCLES=0:
  - Stimulus: write 32'h5 to 12'h000.
  - Required: PREADY=1 in the first access cycle; reg0_out=32'h5 on the next cycle.
- Errors:
  - Misaligned: read 12'h006 -> PSLVERR=1, PRDATA=0.
  - Out of range: write 12'h040 with NUM_REGS=16 -> PSLVERR=1; a read-back of all 16 registers shows no change.
- Abort and reset:
  - Drop PENABLE during the wait of a write -> PREADY never asserts and the register is unchanged.
  - Assert rst=0 mid-access -> PREADY=0 and all registers=0 asynchronously.
- Back-to-back traffic:
  - Stimulus: 8 consecutive writes followed by 8 reads, each setup phase starting the cycle after the previous completion.
  - Required: all transfers complete, with every access phase WAIT_CYCLES+1 cycles long and every read returning the value written.
